// File: rtl/elev_pkg.sv
// Shared types and helpers for the SCAN elevator controller.
// Helpers take a zero-extended request vector, so NUM_FLOORS must not exceed MAX_FLOORS.
package elev_pkg;

    localparam int MAX_FLOORS = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPEN = 2'd1,
        MOVE = 2'd2
    } state_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    function automatic logic any_above(input logic [MAX_FLOORS-1:0] req, input int flr);
        logic found;
        found = 1'b0;
        for (int i = 0; i < MAX_FLOORS; i++) begin
            if (req[i] && (i > flr)) found = 1'b1;
        end
        return found;
    endfunction

    function automatic logic any_below(input logic [MAX_FLOORS-1:0] req, input int flr);
        logic found;
        found = 1'b0;
        for (int i = 0; i < MAX_FLOORS; i++) begin
            if (req[i] && (i < flr)) found = 1'b1;
        end
        return found;
    endfunction

endpackage

// File: rtl/elev_req_latch.sv
// Pending-request register: buttons set bits, the served floor clears its bit.
// A clear on the same cycle as a press of that floor wins.
module elev_req_latch #(
    parameter int NUM_FLOORS = 8,
    localparam int FW = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic [NUM_FLOORS-1:0] set_vec,
    input  logic [FW-1:0]         clr_idx,
    input  logic                  clr_en,
    output logic [NUM_FLOORS-1:0] pending
);

    for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_bit
        logic bit_reg;

        always_ff @(posedge clk) begin
            if (srst) begin
                bit_reg <= 1'b0;
            end else if (clr_en && (clr_idx == FW'(gi))) begin
                bit_reg <= 1'b0;
            end else if (set_vec[gi]) begin
                bit_reg <= 1'b1;
            end
        end

        assign pending[gi] = bit_reg;
    end

endmodule

// File: rtl/elev_ctrl_scan.sv
// N-floor elevator controller serving latched requests in SCAN order,
// with programmable door-open and per-floor travel times.
module elev_ctrl_scan
    import elev_pkg::*;
#(
    parameter int NUM_FLOORS    = 8,
    parameter int DOOR_CYCLES   = 3,
    parameter int TRAVEL_CYCLES = 2,
    localparam int FW = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] floorBtn,
    input  logic                  doorHold,
    output logic [FW-1:0]         floorSel,
    output logic                  door,
    output logic                  dir,
    output logic                  moving,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int TW = $clog2(DOOR_CYCLES + 1);
    localparam int CW = $clog2(TRAVEL_CYCLES + 1);

    state_t          state_reg, state_next;
    logic [FW-1:0]   floor_reg, floor_next;
    logic            dir_reg, dir_next;
    logic [TW-1:0]   timer_reg, timer_next;
    logic [CW-1:0]   travel_reg, travel_next;
    logic            door_reg, moving_reg;

    logic [NUM_FLOORS-1:0] req;
    logic [MAX_FLOORS-1:0] req_wide;
    logic                  ahead, behind, arr_ahead;
    logic [FW-1:0]         arr_floor;

    assign req = pending | floorBtn;

    always_comb begin
        req_wide = '0;
        req_wide[NUM_FLOORS-1:0] = req;
    end

    always_comb begin
        state_next  = state_reg;
        floor_next  = floor_reg;
        dir_next    = dir_reg;
        timer_next  = timer_reg;
        travel_next = travel_reg;
        ahead     = (dir_reg == DIR_UP) ? any_above(req_wide, int'(floor_reg))
                                        : any_below(req_wide, int'(floor_reg));
        behind    = (dir_reg == DIR_UP) ? any_below(req_wide, int'(floor_reg))
                                        : any_above(req_wide, int'(floor_reg));
        arr_floor = (dir_reg == DIR_UP) ? floor_reg + FW'(1) : floor_reg - FW'(1);
        arr_ahead = (dir_reg == DIR_UP) ? any_above(req_wide, int'(arr_floor))
                                        : any_below(req_wide, int'(arr_floor));

        case (state_reg)
            IDLE: begin
                if (req_wide[floor_reg]) begin
                    state_next = OPEN;
                    timer_next = TW'(DOOR_CYCLES);
                end else if (ahead) begin
                    state_next  = MOVE;
                    travel_next = '0;
                end else if (behind) begin
                    state_next  = MOVE;
                    travel_next = '0;
                    dir_next    = ~dir_reg;
                end
            end
            OPEN: begin
                if (floorBtn[floor_reg] || doorHold) begin
                    timer_next = TW'(DOOR_CYCLES);
                end else if (timer_reg == TW'(1)) begin
                    if (ahead) begin
                        state_next  = MOVE;
                        travel_next = '0;
                    end else if (behind) begin
                        state_next  = MOVE;
                        travel_next = '0;
                        dir_next    = ~dir_reg;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    timer_next = timer_reg - TW'(1);
                end
            end
            MOVE: begin
                if (travel_reg == CW'(TRAVEL_CYCLES - 1)) begin
                    // Arrival: the floor steps and the stop decision uses the new floor.
                    travel_next = '0;
                    floor_next  = arr_floor;
                    if (req_wide[arr_floor]) begin
                        state_next = OPEN;
                        timer_next = TW'(DOOR_CYCLES);
                    end else if (!arr_ahead) begin
                        if (|req) dir_next = ~dir_reg;
                        else      state_next = IDLE;
                    end
                end else begin
                    travel_next = travel_reg + CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= OPEN;
            floor_reg  <= '0;
            dir_reg    <= DIR_UP;
            timer_reg  <= TW'(DOOR_CYCLES);
            travel_reg <= '0;
            door_reg   <= 1'b1;
            moving_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            floor_reg  <= floor_next;
            dir_reg    <= dir_next;
            timer_reg  <= timer_next;
            travel_reg <= travel_next;
            door_reg   <= (state_next == OPEN);
            moving_reg <= (state_next == MOVE);
        end
    end

    elev_req_latch #(.NUM_FLOORS(NUM_FLOORS)) u_req_latch (
        .clk     (clk),
        .srst    (rst),
        .set_vec (floorBtn),
        .clr_idx (floor_next),
        .clr_en  (state_next == OPEN),
        .pending (pending)
    );

    assign floorSel = floor_reg;
    assign door     = door_reg;
    assign dir      = dir_reg;
    assign moving   = moving_reg;

endmodule

// File: tb/tb_elev_ctrl_scan.sv
// Bench for elev_ctrl_scan: directed scenarios plus random traffic checked
// against a cycle-level behavioural elevator model.
module tb_elev_ctrl_scan;

    localparam int NF = 8;
    localparam int DC = 3;
    localparam int TC = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NF-1:0] floorBtn = '0;
    logic          doorHold = 1'b0;
    logic [2:0]    floorSel;
    logic          door, dir, moving;
    logic [NF-1:0] pending;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Behavioural model: mode 0=idle, 1=door open, 2=travelling.
    int       m_mode, m_floor, m_dir, m_left, m_trav;
    bit [7:0] m_pend;

    elev_ctrl_scan #(.NUM_FLOORS(NF), .DOOR_CYCLES(DC), .TRAVEL_CYCLES(TC)) dut (
        .clk(clk), .rst(rst), .floorBtn(floorBtn), .doorHold(doorHold),
        .floorSel(floorSel), .door(door), .dir(dir), .moving(moving), .pending(pending)
    );

    always #5 clk = ~clk;

    function automatic bit want(input bit [7:0] r, input int f, input int up);
        for (int i = 0; i < NF; i++)
            if (r[i] && (up != 0 ? i > f : i < f)) return 1'b1;
        return 1'b0;
    endfunction

    // Leave a stop (door closing or idle start): head on, turn around, or rest.
    task automatic m_depart(input bit [7:0] r);
        if (want(r, m_floor, m_dir)) begin
            m_mode = 2; m_trav = TC;
        end else if (want(r, m_floor, 1 - m_dir)) begin
            m_dir = 1 - m_dir; m_mode = 2; m_trav = TC;
        end else begin
            m_mode = 0;
        end
    endtask

    task automatic model_step(input bit [7:0] btn, input bit hold, input bit r);
        bit [7:0] rq;
        rq = m_pend | btn;
        if (r) begin
            m_mode = 1; m_floor = 0; m_dir = 1; m_left = DC; m_pend = '0;
            return;
        end
        case (m_mode)
            0: if (rq[m_floor]) begin m_mode = 1; m_left = DC; end
               else m_depart(rq);
            1: if (btn[m_floor] || hold) m_left = DC;
               else if (m_left > 1) m_left--;
               else m_depart(rq);
            default: begin
                m_trav--;
                if (m_trav == 0) begin
                    m_floor = m_floor + (m_dir != 0 ? 1 : -1);
                    if (rq[m_floor]) begin m_mode = 1; m_left = DC; end
                    else m_depart(rq);
                end
            end
        endcase
        m_pend = rq;
        if (m_mode == 1) m_pend[m_floor] = 1'b0;
    endtask

    function automatic logic [13:0] exp_vec();
        return {3'(m_floor), m_mode == 1, m_dir[0], m_mode == 2, m_pend};
    endfunction

    function automatic logic [13:0] act_vec();
        return {floorSel, door, dir, moving, pending};
    endfunction

    task automatic tick(input logic [7:0] btn, input logic hold, input logic r);
        @(negedge clk);
        floorBtn = btn; doorHold = hold; rst = r;
        @(posedge clk);
        model_step(btn, hold, r);
        #1;
        cyc++;
        $display("cyc=%0d btn=%h hold=%b rst=%b floor=%0d door=%b dir=%b mov=%b pend=%h",
                 cyc, btn, hold, r, floorSel, door, dir, moving, pending);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) tick(8'h00, 1'b0, 1'b1);
        checks++;
        if (act_vec() !== {3'd0, 1'b1, 1'b1, 1'b0, 8'h00}) begin
            errors++; $display("FAIL reset_state got %h want %h", act_vec(), {3'd0, 3'b110, 8'h00});
        end
        for (int i = 0; i < 2; i++) begin
            tick(8'h00, 1'b0, 1'b0);
            checks++;
            if (door !== 1'b1) begin errors++; $display("FAIL reset_door_open got %b want 1", door); end
        end
        tick(8'h00, 1'b0, 1'b0);
        checks++;
        if ({door, moving} !== 2'b00) begin
            errors++; $display("FAIL reset_to_idle got %b want 00", {door, moving});
        end
    endtask

    task automatic test_open_here();
        tick(8'h01, 1'b0, 1'b0);
        checks++;
        if ({door, pending} !== {1'b1, 8'h00}) begin
            errors++; $display("FAIL open_here got %h want 100", {door, pending});
        end
        for (int i = 0; i < 3; i++) begin
            tick(8'h00, 1'b0, 1'b0);
            checks++;
            if (door !== (i < 2)) begin errors++; $display("FAIL open_here_hold%0d got %b want %b", i, door, i < 2); end
        end
    endtask

    task automatic test_travel();
        logic [2:0] want_floor;
        tick(8'h08, 1'b0, 1'b0);
        checks++;
        if (moving !== 1'b1) begin errors++; $display("FAIL travel_start got %b want 1", moving); end
        for (int e = 1; e <= 6; e++) begin
            tick(8'h00, 1'b0, 1'b0);
            want_floor = 3'(e / 2);
            checks++;
            if (floorSel !== want_floor) begin
                errors++; $display("FAIL travel_floor_k%0d got %0d want %0d", e, floorSel, want_floor);
            end
        end
        checks++;
        if ({door, pending} !== {1'b1, 8'h00}) begin
            errors++; $display("FAIL travel_arrive got %h want 100", {door, pending});
        end
        for (int e = 7; e <= 9; e++) begin
            tick(8'h00, 1'b0, 1'b0);
            checks++;
            if (door !== (e < 9)) begin errors++; $display("FAIL travel_door_k%0d got %b want %b", e, door, e < 9); end
        end
    endtask

    task automatic test_scan();
        int stop_f[$];
        int stop_d[$];
        int exp_f[3] = '{5, 6, 1};
        int exp_d[3] = '{1, 1, 0};
        logic prev_door;
        tick(8'h40, 1'b0, 1'b0);
        tick(8'h22, 1'b0, 1'b0);
        for (int i = 0; i < 50; i++) begin
            prev_door = door;
            tick(8'h00, 1'b0, 1'b0);
            if (door && !prev_door) begin stop_f.push_back(int'(floorSel)); stop_d.push_back(int'(dir)); end
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++; $display("FAIL scan_model got %h want %h", act_vec(), exp_vec());
            end
        end
        checks++;
        if (stop_f.size() !== 3) begin errors++; $display("FAIL scan_stop_count got %0d want 3", stop_f.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= stop_f.size() || stop_f[i] !== exp_f[i] || stop_d[i] !== exp_d[i]) begin
                errors++;
                $display("FAIL scan_stop%0d got floor %0d dir %0d want floor %0d dir %0d",
                         i, (i < stop_f.size()) ? stop_f[i] : -1, (i < stop_d.size()) ? stop_d[i] : -1,
                         exp_f[i], exp_d[i]);
            end
        end
        checks++;
        if ({door, moving, pending} !== 10'h000) begin
            errors++; $display("FAIL scan_idle got %h want 000", {door, moving, pending});
        end
    endtask

    task automatic test_reopen();
        int n;
        tick(8'h04, 1'b0, 1'b0);
        n = 0;
        while (door !== 1'b1 && n < 10) begin tick(8'h00, 1'b0, 1'b0); n++; end
        checks++;
        if (door !== 1'b1 || floorSel !== 3'd2) begin
            errors++; $display("FAIL reopen_arrive got door %b floor %0d want door 1 floor 2", door, floorSel);
        end
        tick(8'h00, 1'b0, 1'b0);
        tick(8'h04, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick(8'h00, 1'b0, 1'b0);
            checks++;
            if ({door, pending} !== {(i < 3), 8'h00}) begin
                errors++; $display("FAIL reopen_btn%0d got %h want %h", i, {door, pending}, {(i < 3), 8'h00});
            end
        end
        tick(8'h04, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(8'h00, 1'b1, 1'b0);
            checks++;
            if (door !== 1'b1) begin errors++; $display("FAIL reopen_hold%0d got %b want 1", i, door); end
        end
        for (int i = 0; i < 3; i++) begin
            tick(8'h00, 1'b0, 1'b0);
            checks++;
            if (door !== (i < 2)) begin errors++; $display("FAIL reopen_release%0d got %b want %b", i, door, i < 2); end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        tick(8'h80, 1'b0, 1'b0);
        n = 0;
        while (!(floorSel === 3'd4 && moving === 1'b1) && n < 20) begin tick(8'h00, 1'b0, 1'b0); n++; end
        checks++;
        if ({floorSel, moving, pending} !== {3'd4, 1'b1, 8'h80}) begin
            errors++; $display("FAIL midtrip_setup got %h want %h", {floorSel, moving, pending}, {3'd4, 1'b1, 8'h80});
        end
        tick(8'h00, 1'b0, 1'b1);
        checks++;
        if (act_vec() !== {3'd0, 1'b1, 1'b1, 1'b0, 8'h00}) begin
            errors++; $display("FAIL midtrip_reset got %h want %h", act_vec(), {3'd0, 3'b110, 8'h00});
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic       h, r;
        for (int i = 0; i < 400; i++) begin
            b = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
            h = ($urandom_range(0, 15) == 0);
            r = ($urandom_range(0, 199) == 0);
            tick(b, h, r);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++; $display("FAIL random_cyc%0d got %h want %h", cyc, act_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        m_mode = 1; m_floor = 0; m_dir = 1; m_left = DC; m_trav = 0; m_pend = '0;
        test_reset();
        test_open_here();
        test_travel();
        test_scan();
        test_reopen();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
